// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
//   Read-side drain stage for a synchronous FIFO, clocked by the FIFO read
//   clock. It issues single-cycle read strobes while the FIFO is non-empty,
//   captures the returned word one cycle later, and re-presents it as a
//   valid/ready stream from a 2-entry output buffer. Reads are issued only
//   when a buffer slot is guaranteed for the returning word, so the FIFO is
//   never over-read under back-pressure.
//
// Ports
//   clk_i         read-domain clock
//   rst_i         asynchronous active-high reset
//   enable_i      1 = drain FIFO, 0 = stop reading and flush what is in flight
//   fifo_empty_i  FIFO empty flag (read domain)
//   fifo_data_i   FIFO read data, valid the cycle after an accepted strobe
//   fifo_rd_o     FIFO read strobe (combinational)
//   fifo_oe_o     FIFO output-latch enable, high whenever out of reset
//   m_data_o      stream data (buffer head)
//   m_valid_o     stream valid
//   m_ready_i     stream ready
//   rd_count_o    words delivered (valid & ready), wraps
//   busy_o        high while the controller is not idle
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_rd_o,
  output logic                  fifo_oe_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [CNT_WIDTH-1:0]  rd_count_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state, state_nxt;
  logic                    vld_p1;   // strobe accepted last cycle, word on fifo_data_i now
  logic [1:0]              occ_p2;   // words held in the output buffer
  logic [DATA_WIDTH-1:0]   head_p2;
  logic [DATA_WIDTH-1:0]   tail_p2;
  logic                    pop;

  // A new strobe is allowed only if every word already committed (buffered
  // plus in flight, minus the one leaving this cycle) leaves a free slot.
  function automatic logic has_credit(input logic [1:0] occ_f,
                                      input logic       infl_f,
                                      input logic       pop_f);
    logic [2:0] committed;
    committed = {1'b0, occ_f} + {2'b00, infl_f} - {2'b00, pop_f};
    return committed < 3'd2;
  endfunction

  assign pop       = m_valid_o & m_ready_i;
  assign m_valid_o = (occ_p2 != 2'd0);
  assign m_data_o  = head_p2;
  assign busy_o    = (state != IDLE);

  // ---- p0: read issue
  assign fifo_rd_o = (state == RUN) & enable_i & ~fifo_empty_i &
                     has_credit(occ_p2, vld_p1, pop);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (enable_i) state_nxt = RUN;
      RUN:     if (!enable_i) state_nxt = DRAIN;
      DRAIN: begin
        if (enable_i)                           state_nxt = RUN;
        else if (!vld_p1 && (occ_p2 == 2'd0))   state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      vld_p1     <= 1'b0;
      occ_p2     <= 2'd0;
      rd_count_o <= '0;
      fifo_oe_o  <= 1'b0;
    end else begin
      state      <= state_nxt;
      fifo_oe_o  <= 1'b1;
      // ---- p1: word returning from the FIFO
      vld_p1     <= fifo_rd_o;
      // ---- p2: output buffer occupancy and delivery count
      occ_p2     <= occ_p2 + {1'b0, vld_p1} - {1'b0, pop};
      if (pop) rd_count_o <= rd_count_o + CNT_ONE;
    end
  end

  // ---- p2: output buffer data. The head is reset because it drives
  // m_data_o directly; the tail is never observed until written.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_p2 <= '0;
    end else begin
      if (pop) begin
        // Leaving word is replaced by the queued tail, or by the arriving
        // word when it was the only one held.
        head_p2 <= (occ_p2 == 2'd2) ? tail_p2 : fifo_data_i;
      end else if (vld_p1 && (occ_p2 == 2'd0)) begin
        head_p2 <= fifo_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (vld_p1 && (((occ_p2 == 2'd2) && pop) || ((occ_p2 == 2'd1) && !pop)))
      tail_p2 <= fifo_data_i;
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic        fifo_empty_i;
  logic [7:0]  fifo_data_i;
  logic        m_ready_i;

  logic        fifo_rd_o, fifo_oe_o, m_valid_o, busy_o;
  logic [7:0]  m_data_o;
  logic [15:0] rd_count_o;

  logic        rd_w, oe_w, valid_w, busy_w;
  logic [7:0]  data_w;
  logic [3:0]  cnt_w;

  always #5 clk = ~clk;

  fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i),
    .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i),
    .fifo_rd_o(fifo_rd_o), .fifo_oe_o(fifo_oe_o),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .rd_count_o(rd_count_o), .busy_o(busy_o)
  );

  // Narrow-counter instance sharing all inputs, for the wrap boundary.
  fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut_w (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i),
    .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i),
    .fifo_rd_o(rd_w), .fifo_oe_o(oe_w),
    .m_data_o(data_w), .m_valid_o(valid_w), .m_ready_i(m_ready_i),
    .rd_count_o(cnt_w), .busy_o(busy_w)
  );

  typedef struct packed {
    logic [7:0] d;
    int         c;
  } ent_t;

  typedef struct {
    logic        en;
    logic        rdy;
    int          npush;
    logic [7:0]  seed;
    int          ncyc;
    int          exp_pulses;
    logic [15:0] exp_cnt;
  } step_t;

  // FIFO contents, and words already strobed but not yet delivered
  logic [7:0]  fq[$];
  ent_t        oq[$];
  int          st;        // 0 idle, 1 running, 2 draining
  int          cyc;
  logic [15:0] exp_cnt;
  logic [7:0]  nxt_byte;
  int          step_pulses;
  int          nvec;
  int          nfail;
  step_t       steps [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, ".fifo_rd"}, fifo_rd_o, 0);
    chk({tag, ".fifo_oe"}, fifo_oe_o, 0);
    chk({tag, ".m_valid"}, m_valid_o, 0);
    chk({tag, ".m_data"},  m_data_o, 0);
    chk({tag, ".count"},   rd_count_o, 0);
    chk({tag, ".busy"},    busy_o, 0);
    chk({tag, ".w_count"}, cnt_w, 0);
    chk({tag, ".w_valid"}, valid_w, 0);
  endtask

  task automatic push_n(input int n, input logic [7:0] seed);
    if (seed != 8'h00) nxt_byte = seed;
    for (int i = 0; i < n; i++) begin
      fq.push_back(nxt_byte);
      nxt_byte = nxt_byte + 8'h01;
    end
    if (n > 0) fifo_empty_i = 1'b0;
  endtask

  task automatic push_rand();
    fq.push_back(8'($urandom));
    fifo_empty_i = 1'b0;
  endtask

  // One clock cycle: predict outputs from the stream rules, compare at the
  // falling edge, then advance the model and the FIFO after the rising edge.
  task automatic cycle();
    int         out_cnt;
    int         nst;
    logic       e_valid, e_pop, e_rd, e_busy, dut_rd;
    logic [7:0] e_data;
    @(negedge clk);
    out_cnt = oq.size();
    e_valid = 1'b0;
    e_data  = 8'h00;
    if (out_cnt > 0 && oq[0].c <= cyc - 2) begin
      e_valid = 1'b1;
      e_data  = oq[0].d;
    end
    e_pop  = e_valid && m_ready_i;
    e_rd   = (st == 1) && enable_i && !fifo_empty_i && ((out_cnt - (e_pop ? 1 : 0)) < 2);
    e_busy = (st != 0);

    chk("fifo_rd", fifo_rd_o, e_rd);
    chk("m_valid", m_valid_o, e_valid);
    if (e_valid) chk("m_data", m_data_o, e_data);
    chk("busy", busy_o, e_busy);
    chk("count", rd_count_o, exp_cnt);
    chk("fifo_oe", fifo_oe_o, 1);
    chk("w_fifo_rd", rd_w, e_rd);
    chk("w_valid", valid_w, e_valid);
    if (e_valid) chk("w_data", data_w, e_data);
    chk("w_busy", busy_w, e_busy);
    chk("w_oe", oe_w, 1);
    chk("w_count", cnt_w, exp_cnt[3:0]);

    if (fifo_rd_o) step_pulses++;
    case (st)
      0:       nst = enable_i ? 1 : 0;
      1:       nst = enable_i ? 1 : 2;
      default: nst = enable_i ? 1 : ((out_cnt == 0) ? 0 : 2);
    endcase
    if (e_rd && fq.size() > 0) oq.push_back('{d: fq[0], c: cyc});
    dut_rd = fifo_rd_o;

    @(posedge clk);
    cyc++;
    #1;
    if (e_pop) begin
      void'(oq.pop_front());
      exp_cnt = exp_cnt + 16'd1;
    end
    st = nst;
    if (dut_rd && fq.size() > 0) fifo_data_i = fq.pop_front();
    fifo_empty_i = (fq.size() == 0);
  endtask

  initial begin
    nvec = 0; nfail = 0; cyc = 0; st = 0; exp_cnt = 16'd0; nxt_byte = 8'h01;
    step_pulses = 0;
    rst_i = 1'b1; enable_i = 1'b0; m_ready_i = 1'b0;
    fifo_empty_i = 1'b1; fifo_data_i = 8'h00;

    //          en    rdy   push seed   cyc pulses count
    steps[0] = '{1'b1, 1'b1, 16, 8'h01, 24, 16, 16'd16}; // streaming
    steps[1] = '{1'b1, 1'b0, 16, 8'h01, 10,  2, 16'd16}; // stall: two strobes only
    steps[2] = '{1'b1, 1'b1,  0, 8'h00, 24, 14, 16'd32}; // release stall
    steps[3] = '{1'b1, 1'b1,  1, 8'hA5,  6,  1, 16'd33}; // single word into empty FIFO
    steps[4] = '{1'b1, 1'b1,  0, 8'h00,  6,  0, 16'd33}; // stays idle while empty
    steps[5] = '{1'b1, 1'b1, 16, 8'h01,  5,  5, 16'd36}; // five strobes
    steps[6] = '{1'b0, 1'b1,  0, 8'h00,  8,  0, 16'd38}; // disable, flush in-flight
    steps[7] = '{1'b1, 1'b1,  0, 8'h00, 20, 11, 16'd49}; // re-enable, remaining 11
    steps[8] = '{1'b0, 1'b1,  0, 8'h00,  4,  0, 16'd49}; // back to idle

    // Power-on reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_rst("por");
    end
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(posedge clk); #1;
    chk("oe_after_release", fifo_oe_o, 1);
    chk("w_oe_after_release", oe_w, 1);

    // Directed table
    for (int s = 0; s < 9; s++) begin
      enable_i  = steps[s].en;
      m_ready_i = steps[s].rdy;
      push_n(steps[s].npush, steps[s].seed);
      step_pulses = 0;
      for (int c = 0; c < steps[s].ncyc; c++) cycle();
      chk($sformatf("step%0d.pulses", s), step_pulses, steps[s].exp_pulses);
      chk($sformatf("step%0d.count", s), rd_count_o, steps[s].exp_cnt);
      chk($sformatf("step%0d.w_count", s), cnt_w, steps[s].exp_cnt[3:0]);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      enable_i  = ($urandom_range(7) != 0);
      m_ready_i = ($urandom_range(2) != 0);
      if ($urandom_range(1) == 1 && fq.size() < 32) push_rand();
      cycle();
    end
    enable_i = 1'b1; m_ready_i = 1'b1;
    for (int c = 0; c < 80; c++) cycle();
    chk("rand.fifo_drained", fq.size(), 0);
    chk("rand.valid_low", m_valid_o, 0);

    // Asynchronous reset mid-transfer with a full buffer
    enable_i = 1'b1; m_ready_i = 1'b0;
    push_n(8, 8'h40);
    for (int c = 0; c < 4; c++) cycle();
    chk("pre_rst.valid", m_valid_o, 1);
    #2;
    rst_i = 1'b1;
    #1;
    chk_rst("async");
    oq.delete(); fq.delete();
    st = 0; exp_cnt = 16'd0;
    enable_i = 1'b0; fifo_empty_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_rst("held");
    end
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(posedge clk); #1;
    chk("oe_after_async", fifo_oe_o, 1);
    m_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) cycle();
    chk("post_rst.count", rd_count_o, 0);

    // Fresh traffic after reset
    enable_i = 1'b1;
    push_n(4, 8'hC0);
    step_pulses = 0;
    for (int c = 0; c < 12; c++) cycle();
    chk("post_rst.pulses", step_pulses, 4);
    chk("post_rst.delivered", rd_count_o, 4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
